// File: rtl/bcd_seg_scan_pkg.sv
// Shared constants for the BCD 7-segment scanner: active-low segment patterns
// ordered {g,f,e,d,c,b,a} and the all-anodes-off value.
package bcd_seg_scan_pkg;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
   import bcd_seg_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup, dash for any non-decimal code
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Four-digit common-anode 7-segment scanner with a refresh divider,
// frame-synchronous double buffering, leading-zero blanking and dash for
// invalid digits. All display outputs are registered (one cycle behind idx).
module bcd_seg_scan
   import bcd_seg_scan_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        load,
   input  logic [3:0]  dp_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [1:0]       idx_q;
   logic [15:0]      pend_q;
   logic [3:0]       pend_dp_q;
   logic [15:0]      disp_q;
   logic [3:0]       disp_dp_q;

   logic             slot_end;
   logic             frame_end;
   logic [3:0]       blank;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_seg;

   assign slot_end  = (div_q == DIV_LAST);
   assign frame_end = slot_end && (idx_q == 2'd3);
   assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

   // Leading-zero blanking: a digit blanks only if it and every digit to its left is zero
   always_comb begin
      blank = 4'b0000;
      if (BLANK_LZ) begin
         blank[3] = (disp_q[15:12] == 4'd0);
         blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
         blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   // Refresh divider and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= 2'd0;
      end else if (slot_end) begin
         div_q <= '0;
         idx_q <= idx_q + 2'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Double buffer: loads land in pending; display copies pending only at frame end,
   // so a load on the boundary edge appears one frame later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= 16'h0000;
         pend_dp_q <= 4'b0000;
         disp_q    <= 16'h0000;
         disp_dp_q <= 4'b0000;
      end else begin
         if (load) begin
            pend_q    <= din;
            pend_dp_q <= dp_en;
         end
         if (frame_end) begin
            disp_q    <= pend_q;
            disp_dp_q <= pend_dp_q;
         end
      end
   end

   // Registered display outputs and frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (blank[idx_q]) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << idx_q);
            seg <= cur_seg;
            dp  <= ~disp_dp_q[idx_q];
         end
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (CLK_DIV=4, BLANK_LZ=1). A cycle-count
// reference model predicts every output; scenario tasks add literal checks.
module tb_bcd_seg_scan;

   localparam int unsigned CLK_DIV = 4;
   localparam int          FRAME   = 4 * CLK_DIV;
   localparam bit          BLANK   = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        load = 1'b0;
   logic [3:0]  dp_en = 4'b0000;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference model state: n_m counts clock edges since reset release
   int          n_m = 0;
   logic [15:0] pend_m = 16'h0000;
   logic [3:0]  pend_dp_m = 4'b0000;
   logic [15:0] disp_m = 16'h0000;
   logic [3:0]  disp_dp_m = 4'b0000;
   logic [3:0]  exp_an = 4'hF;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_dp = 1'b1;
   logic        exp_ft = 1'b0;

   logic [6:0] segtab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   bcd_seg_scan #(
      .CLK_DIV  (CLK_DIV),
      .BLANK_LZ (BLANK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .load       (load),
      .dp_en      (dp_en),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   initial forever #5 clk = ~clk;

   // Expected {an, seg, dp} for showing digit i of buffer d
   function automatic logic [11:0] expect_out(input int i, input logic [15:0] d,
                                              input logic [3:0] dpe);
      logic [15:0] sh;
      sh = d >> (4 * i);
      if (BLANK && i > 0 && sh == 16'h0000) return {4'hF, 7'h7F, 1'b1};
      return {~(4'b0001 << i), segtab[int'(sh[3:0])], ~dpe[i]};
   endfunction

   // Model: outputs after an edge show the slot/buffer that held before it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_m       <= 0;
         pend_m    <= 16'h0000;
         pend_dp_m <= 4'b0000;
         disp_m    <= 16'h0000;
         disp_dp_m <= 4'b0000;
         exp_an    <= 4'hF;
         exp_seg   <= 7'h7F;
         exp_dp    <= 1'b1;
         exp_ft    <= 1'b0;
      end else begin
         {exp_an, exp_seg, exp_dp} <= expect_out((n_m / CLK_DIV) % 4, disp_m, disp_dp_m);
         exp_ft <= ((n_m + 1) % FRAME == 0);
         if ((n_m + 1) % FRAME == 0) begin
            disp_m    <= pend_m;
            disp_dp_m <= pend_dp_m;
         end
         if (load) begin
            pend_m    <= din;
            pend_dp_m <= dp_en;
         end
         n_m <= n_m + 1;
      end
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      din   = v;
      dp_en = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Advance at least one cycle, stopping where the edge count sits at phase p
   task automatic to_phase(input int p);
      @(negedge clk);
      for (int k = 0; k < FRAME && (n_m % FRAME) != p; k++) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [11:0] want;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
                     an, seg, dp, frame_tick);
         end
      end
      rst_n = 1'b1;
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         want = ((k - 1) / CLK_DIV == 0) ? {4'b1110, 7'b1000000, 1'b1}
                                         : {4'b1111, 7'b1111111, 1'b1};
         checks++;
         if ({an, seg, dp, frame_tick} !== {want, (k == FRAME)}) begin
            errors++;
            $display("FAIL reset_scan k=%0d got an=%b seg=%b dp=%b ft=%b want %b ft=%b",
                     k, an, seg, dp, frame_tick, want, (k == FRAME));
         end
      end
   endtask

   task automatic test_load_blank;
      logic [10:0] want;
      do_load(16'h0025, 4'b0000);
      to_phase(0);
      repeat (FRAME) begin
         @(negedge clk);
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL blank_model got %b %b %b %b want %b %b %b %b",
                     an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         want = 11'h0;
         case (n_m % FRAME)
            1:       want = {4'b1110, 7'b0010010};
            5:       want = {4'b1101, 7'b0100100};
            9, 13:   want = {4'b1111, 7'b1111111};
            default: want = {an, seg};
         endcase
         if ((n_m % FRAME) % CLK_DIV == 1) begin
            checks++;
            if ({an, seg} !== want) begin
               errors++;
               $display("FAIL blank_digit ph=%0d got an=%b seg=%b want %b",
                        n_m % FRAME, an, seg, want);
            end
         end
      end
   endtask

   task automatic test_mid_frame;
      logic [10:0] want;
      to_phase(5);
      do_load(16'h1234, 4'b0000);
      for (int k = 0; k < FRAME && (n_m % FRAME) != 0; k++) begin
         @(negedge clk);
         if ((n_m % FRAME) == 9) begin
            checks++;
            if (an !== 4'b1111) begin
               errors++;
               $display("FAIL mid_old_frame got an=%b want 1111", an);
            end
         end
      end
      repeat (FRAME) begin
         @(negedge clk);
         want = 11'h0;
         case (n_m % FRAME)
            1:       want = {4'b1110, 7'b0011001};
            5:       want = {4'b1101, 7'b0110000};
            9:       want = {4'b1011, 7'b0100100};
            13:      want = {4'b0111, 7'b1111001};
            default: want = {exp_an, exp_seg};
         endcase
         checks++;
         if ({an, seg, dp} !== {want, 1'b1}) begin
            errors++;
            $display("FAIL mid_new_frame ph=%0d got an=%b seg=%b dp=%b want %b dp=1",
                     n_m % FRAME, an, seg, dp, want);
         end
      end
   endtask

   task automatic test_boundary_load;
      to_phase(FRAME - 1);
      do_load(16'h5678, 4'b0000);
      for (int f = 0; f < 2; f++) begin
         repeat (FRAME) begin
            @(negedge clk);
            if ((n_m % FRAME) == 1) begin
               checks++;
               if (seg !== ((f == 0) ? 7'b0011001 : 7'b0000000)) begin
                  errors++;
                  $display("FAIL boundary_frame%0d got seg=%b want %b", f, seg,
                           (f == 0) ? 7'b0011001 : 7'b0000000);
               end
            end
            if ((n_m % FRAME) == 13 && f == 1) begin
               checks++;
               if ({an, seg} !== {4'b0111, 7'b0010010}) begin
                  errors++;
                  $display("FAIL boundary_d3 got an=%b seg=%b want 0111 0010010", an, seg);
               end
            end
         end
      end
   endtask

   task automatic test_invalid_dp;
      logic [11:0] want;
      do_load(16'h0A07, 4'b0001);
      to_phase(0);
      repeat (FRAME) begin
         @(negedge clk);
         want = 12'h0;
         case (n_m % FRAME)
            1:       want = {4'b1110, 7'b1111000, 1'b0};
            5:       want = {4'b1101, 7'b1000000, 1'b1};
            9:       want = {4'b1011, 7'b0111111, 1'b1};
            13:      want = {4'b1111, 7'b1111111, 1'b1};
            default: want = {exp_an, exp_seg, exp_dp};
         endcase
         checks++;
         if ({an, seg, dp} !== want) begin
            errors++;
            $display("FAIL invalid_dp ph=%0d got an=%b seg=%b dp=%b want %b",
                     n_m % FRAME, an, seg, dp, want);
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] v;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL random c=%0d got %b %b %b %b want %b %b %b %b", c,
                     an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
         load = ($urandom_range(0, 5) == 0);
         for (int d = 0; d < 4; d++)
            v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         din   = v;
         dp_en = 4'($urandom_range(0, 15));
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_load(16'h1234, 4'b0010);
      to_phase(0);
      to_phase(9);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_async got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
                  an, seg, dp, frame_tick);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'b1110, 7'b1000000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_restart got an=%b seg=%b dp=%b ft=%b want 1110 1000000 1 0",
                  an, seg, dp, frame_tick);
      end
      repeat (FRAME) begin
         @(negedge clk);
         checks++;
         if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
            errors++;
            $display("FAIL reset_cleared got %b %b %b %b want %b %b %b %b",
                     an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_blank();
      test_mid_frame();
      test_boundary_load();
      test_invalid_dp();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
